// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Brief    : Single-outstanding instruction fetch unit (WBU -> imem -> IDU).
//            Optional watchdog enabled by defining IFU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        WBU_valid,
    output logic        IFU_ready,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        imem_rready,
    output logic        IFU_valid,
    input  logic        IDU_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam logic [2:0] ST_BOOT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] fetch_addr;
    logic        timeout;

`ifdef IFU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;

    // Counter is held at zero outside ADDR/DATA, so every ADDR entry starts from 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= 8'd0;
        end else if (state == ST_ADDR || state == ST_DATA) begin
            wd_cnt <= wd_cnt + 8'd1;
        end else begin
            wd_cnt <= 8'd0;
        end
    end

    assign timeout = (state == ST_ADDR || state == ST_DATA) && (wd_cnt == TO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_ADDR;
            ST_IDLE: begin
                if (WBU_valid) begin
                    state_next = (pc[1:0] == 2'b00) ? ST_ADDR : ST_HOLD;
                end
            end
            ST_ADDR: begin
                if (timeout) begin
                    state_next = ST_HOLD;
                end else if (imem_arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (imem_rvalid || timeout) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (IDU_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        IFU_ready    = (state == ST_IDLE);
        imem_arvalid = (state == ST_ADDR);
        imem_rready  = (state == ST_DATA);
        IFU_valid    = (state == ST_HOLD);
        imem_araddr  = fetch_addr;
    end

    // Faulted fetches report inst = 0 so IDU never sees garbage bus data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_addr  <= 32'd0;
            inst        <= 32'd0;
            inst_pc     <= 32'd0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: fetch_addr <= RESET_PC;
                ST_IDLE: begin
                    if (WBU_valid) begin
                        fetch_addr <= pc;
                        if (pc[1:0] != 2'b00) begin
                            inst        <= 32'd0;
                            inst_pc     <= pc;
                            fetch_fault <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (timeout) begin
                        inst        <= 32'd0;
                        inst_pc     <= fetch_addr;
                        fetch_fault <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (imem_rvalid) begin
                        inst        <= (imem_rresp != 2'b00) ? 32'd0 : imem_rdata;
                        inst_pc     <= fetch_addr;
                        fetch_fault <= (imem_rresp != 2'b00);
                    end else if (timeout) begin
                        inst        <= 32'd0;
                        inst_pc     <= fetch_addr;
                        fetch_fault <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Directed self-checking bench for ifu_fetch (IFU_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        WBU_valid;
    logic        IFU_ready;
    logic        imem_arvalid;
    logic [31:0] imem_araddr;
    logic        imem_arready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        imem_rready;
    logic        IFU_valid;
    logic        IDU_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int n_total = 0;
    int n_pass  = 0;

    ifu_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .WBU_valid    (WBU_valid),
        .IFU_ready    (IFU_ready),
        .imem_arvalid (imem_arvalid),
        .imem_araddr  (imem_araddr),
        .imem_arready (imem_arready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .imem_rresp   (imem_rresp),
        .imem_rready  (imem_rready),
        .IFU_valid    (IFU_valid),
        .IDU_ready    (IDU_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .fetch_fault  (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Handshake-type outputs packed as {IFU_ready, arvalid, rready, IFU_valid}.
    function automatic logic [31:0] hs();
        return {28'd0, IFU_ready, imem_arvalid, imem_rready, IFU_valid};
    endfunction

    logic [31:0] held_inst;
    logic [31:0] held_pc;

    initial begin
        rst_n        = 1'b0;
        pc           = 32'd0;
        WBU_valid    = 1'b0;
        imem_arready = 1'b1;
        imem_rvalid  = 1'b1;
        imem_rdata   = 32'h0000_0013;
        imem_rresp   = 2'b00;
        IDU_ready    = 1'b0;

        tick();
        tick();
        check("reset_hs",    hs(), 32'h0);
        check("reset_araddr", imem_araddr, 32'h0);
        check("reset_inst",   inst, 32'h0);
        check("reset_pc",     inst_pc, 32'h0);
        check("reset_fault",  {31'd0, fetch_fault}, 32'h0);

        // Boot fetch with a zero-wait memory
        rst_n = 1'b1;
        tick();
        check("boot_hs",     hs(), 32'h4);
        check("boot_araddr", imem_araddr, 32'h8000_0000);
        tick();
        check("boot_data_hs", hs(), 32'h2);
        tick();
        check("boot_hold_hs", hs(), 32'h1);
        check("boot_inst",    inst, 32'h0000_0013);
        check("boot_inst_pc", inst_pc, 32'h8000_0000);
        check("boot_fault",   {31'd0, fetch_fault}, 32'h0);

        // Sequential fetch of 0x80000004
        IDU_ready = 1'b1;
        tick();
        check("idle_hs", hs(), 32'h8);
        IDU_ready  = 1'b0;
        WBU_valid  = 1'b1;
        pc         = 32'h8000_0004;
        imem_rdata = 32'h0010_0093;
        tick();
        WBU_valid = 1'b0;
        check("seq_addr_hs", hs(), 32'h4);
        check("seq_araddr",  imem_araddr, 32'h8000_0004);
        tick();
        check("seq_data_hs", hs(), 32'h2);
        tick();
        check("seq_hold_hs", hs(), 32'h1);
        check("seq_inst",    inst, 32'h0010_0093);
        check("seq_inst_pc", inst_pc, 32'h8000_0004);

        // Misaligned PC faults immediately without a bus request
        IDU_ready = 1'b1;
        tick();
        IDU_ready = 1'b0;
        WBU_valid = 1'b1;
        pc        = 32'h8000_0002;
        tick();
        WBU_valid = 1'b0;
        check("mis_hs",      hs(), 32'h1);
        check("mis_fault",   {31'd0, fetch_fault}, 32'h1);
        check("mis_inst",    inst, 32'h0);
        check("mis_inst_pc", inst_pc, 32'h8000_0002);

        // Waited fetch: 4 arready waits, 3 rvalid waits, SLVERR response
        IDU_ready = 1'b1;
        tick();
        IDU_ready    = 1'b0;
        WBU_valid    = 1'b1;
        pc           = 32'h8000_0008;
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rresp   = 2'b10;
        imem_rdata   = 32'hDEAD_BEEF;
        tick();
        WBU_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wait_addr_hs", hs(), 32'h4);
            check("wait_araddr",  imem_araddr, 32'h8000_0008);
            tick();
        end
        check("wait_addr_last", hs(), 32'h4);
        check("wait_araddr_last", imem_araddr, 32'h8000_0008);
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wait_data_hs", hs(), 32'h2);
            tick();
        end
        check("wait_data_last", hs(), 32'h2);
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        check("err_hold_hs", hs(), 32'h1);
        check("err_fault",   {31'd0, fetch_fault}, 32'h1);
        check("err_inst",    inst, 32'h0);
        check("err_inst_pc", inst_pc, 32'h8000_0008);

        // IDU back-pressure: HOLD contents stay frozen
        held_inst = inst;
        held_pc   = inst_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hs",      hs(), 32'h1);
            check("stall_inst",    inst, held_inst);
            check("stall_inst_pc", inst_pc, held_pc);
        end

        // Reset in the middle of DATA
        IDU_ready = 1'b1;
        tick();
        IDU_ready    = 1'b0;
        WBU_valid    = 1'b1;
        pc           = 32'h8000_000C;
        imem_arready = 1'b1;
        imem_rresp   = 2'b00;
        tick();
        WBU_valid = 1'b0;
        tick();
        check("pre_rst_data_hs", hs(), 32'h2);
        imem_arready = 1'b0;
        rst_n        = 1'b0;
        tick();
        check("mid_rst_hs",     hs(), 32'h0);
        check("mid_rst_araddr", imem_araddr, 32'h0);
        check("mid_rst_inst",   inst, 32'h0);
        check("mid_rst_pc",     inst_pc, 32'h0);
        check("mid_rst_fault",  {31'd0, fetch_fault}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("refetch_hs",     hs(), 32'h4);
        check("refetch_araddr", imem_araddr, 32'h8000_0000);

        // arready held low: watchdog fault or indefinite wait
`ifdef IFU_TIMEOUT_EN
        for (int i = 0; i < 254; i++) begin
            tick();
            if (i == 253) check("to_still_addr", hs(), 32'h4);
        end
        tick();
        check("to_hold_hs", hs(), 32'h1);
        check("to_fault",   {31'd0, fetch_fault}, 32'h1);
        check("to_inst",    inst, 32'h0);
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
        end
        check("no_to_hs",     hs(), 32'h4);
        check("no_to_araddr", imem_araddr, 32'h8000_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
